// File: rtl/cnn_fifo_drain_if.sv
// Handshake bundle between the test FIFO, the digit source and the framed byte sink.
// master = cnn_fifo_drain, slave = the surrounding FIFO / sink / classifier.
interface cnn_fifo_drain_if;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic [3:0]  digit_i;
  logic        digit_i_valid;
  logic [7:0]  byte_o;
  logic        byte_o_valid;
  logic        byte_o_ready;
  logic        frame_done;

  modport master (
    input  fifo_empty, fifo_dout, digit_i, digit_i_valid, byte_o_ready,
    output fifo_rd_en, byte_o, byte_o_valid, frame_done
  );

  modport slave (
    output fifo_empty, fifo_dout, digit_i, digit_i_valid, byte_o_ready,
    input  fifo_rd_en, byte_o, byte_o_valid, frame_done
  );
endinterface

// File: rtl/cnn_fifo_drain.sv
// Drains 16-bit result words from a non-show-ahead FIFO and emits framed bytes:
// header, payload (high byte first), XOR checksum of the payload, then {seen,000,digit}.
module cnn_fifo_drain #(
  parameter int         FRAME_WORDS = 64,
  parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  cnn_fifo_drain_if.master bus
);

  localparam int            CW   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RD, S_LAT, S_HI, S_LO, S_CSUM, S_DIG
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [7:0]    csum_q;
  logic [7:0]    byte_q;
  logic [7:0]    word_lo_q;
  logic [3:0]    digit_q;
  logic          seen_q;
  logic          accept;

  assign accept = bus.byte_o_valid && bus.byte_o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!bus.fifo_empty) state_d = S_HDR;
      S_HDR:  if (accept)          state_d = S_RD;
      S_RD:   if (!bus.fifo_empty) state_d = S_LAT;
      S_LAT:                       state_d = S_HI;
      S_HI:   if (accept)          state_d = S_LO;
      S_LO:   if (accept)          state_d = (count_q == LAST) ? S_CSUM : S_RD;
      S_CSUM: if (accept)          state_d = S_DIG;
      S_DIG:  if (accept)          state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.fifo_rd_en   = (state_q == S_RD) && !bus.fifo_empty;
    bus.byte_o_valid = state_q inside {S_HDR, S_HI, S_LO, S_CSUM, S_DIG};
    bus.frame_done   = (state_q == S_DIG) && bus.byte_o_ready;
    bus.byte_o       = byte_q;
  end

  // byte_q is loaded when the next byte is decided and then held, so the
  // presented byte never changes while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      csum_q    <= '0;
      byte_q    <= '0;
      word_lo_q <= '0;
      digit_q   <= '0;
      seen_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (!bus.fifo_empty) begin
          byte_q  <= HDR_BYTE;
          csum_q  <= '0;
          count_q <= '0;
        end
        S_LAT: begin
          byte_q    <= bus.fifo_dout[15:8];
          word_lo_q <= bus.fifo_dout[7:0];
        end
        S_HI: if (accept) begin
          csum_q <= csum_q ^ byte_q;
          byte_q <= word_lo_q;
        end
        S_LO: if (accept) begin
          csum_q  <= csum_q ^ byte_q;
          byte_q  <= csum_q ^ byte_q;
          count_q <= count_q + CW'(1);
        end
        S_CSUM: if (accept) byte_q <= {seen_q, 3'b000, digit_q};
        default: ;
      endcase

      // A new digit arriving with the digit-byte handshake survives into the next frame.
      if (bus.digit_i_valid) begin
        digit_q <= bus.digit_i;
        seen_q  <= 1'b1;
      end else if ((state_q == S_DIG) && accept) begin
        seen_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_fifo_drain.sv
// Bench for cnn_fifo_drain: FRAME_WORDS=2 and FRAME_WORDS=1 instances fed by queue-based FIFO models.
module tb_cnn_fifo_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  cnn_fifo_drain_if b0();
  cnn_fifo_drain_if b1();

  cnn_fifo_drain #(.FRAME_WORDS(2), .HDR_BYTE(8'hA5)) u0 (.clk(clk), .rst(rst), .bus(b0));
  cnn_fifo_drain #(.FRAME_WORDS(1), .HDR_BYTE(8'hA5)) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef logic [6:0][7:0] frame_t;
  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    bit          dv;
    logic [3:0]  d;
    bit          rnd;
    frame_t      exp;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  bit rnd0 = 1'b0;

  // FIFO models: non-show-ahead, data appears the cycle after the read strobe
  logic [15:0] fq0[$];
  logic [15:0] fq1[$];
  logic        push0 = 1'b0, push1 = 1'b0, flush0 = 1'b0;
  logic [15:0] pd0 = '0, pd1 = '0;

  always @(posedge clk) begin
    if (flush0) fq0.delete();
    else begin
      if (b0.fifo_rd_en && fq0.size() > 0) b0.fifo_dout <= fq0.pop_front();
      if (push0) fq0.push_back(pd0);
    end
    b0.fifo_empty <= (fq0.size() == 0);
  end

  always @(posedge clk) begin
    if (b1.fifo_rd_en && fq1.size() > 0) b1.fifo_dout <= fq1.pop_front();
    if (push1) fq1.push_back(pd1);
    b1.fifo_empty <= (fq1.size() == 0);
  end

  // Monitors sample on the falling edge: record accepted bytes and protocol violations
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int done0 = 0, rd0 = 0, viol0 = 0, stab0 = 0, bad0 = 0;
  int done1 = 0, rd1 = 0, viol1 = 0, stab1 = 0, bad1 = 0;
  logic hold0 = 1'b0, hold1 = 1'b0;
  logic [7:0] hb0 = '0, hb1 = '0;

  always @(negedge clk) begin
    if (rst) hold0 <= 1'b0;
    else begin
      if (b0.byte_o_valid && b0.byte_o_ready) got0.push_back(b0.byte_o);
      if (b0.frame_done) done0 <= done0 + 1;
      if (b0.frame_done && !(b0.byte_o_valid && b0.byte_o_ready)) bad0 <= bad0 + 1;
      if (b0.fifo_rd_en) rd0 <= rd0 + 1;
      if (b0.fifo_rd_en && b0.fifo_empty) viol0 <= viol0 + 1;
      if (hold0 && !(b0.byte_o_valid && b0.byte_o == hb0)) stab0 <= stab0 + 1;
      hold0 <= b0.byte_o_valid && !b0.byte_o_ready;
      hb0   <= b0.byte_o;
    end
  end

  always @(negedge clk) begin
    if (rst) hold1 <= 1'b0;
    else begin
      if (b1.byte_o_valid && b1.byte_o_ready) got1.push_back(b1.byte_o);
      if (b1.frame_done) done1 <= done1 + 1;
      if (b1.frame_done && !(b1.byte_o_valid && b1.byte_o_ready)) bad1 <= bad1 + 1;
      if (b1.fifo_rd_en) rd1 <= rd1 + 1;
      if (b1.fifo_rd_en && b1.fifo_empty) viol1 <= viol1 + 1;
      if (hold1 && !(b1.byte_o_valid && b1.byte_o == hb1)) stab1 <= stab1 + 1;
      hold1 <= b1.byte_o_valid && !b1.byte_o_ready;
      hb1   <= b1.byte_o;
    end
  end

  function automatic frame_t mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6);
    frame_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5; r[6] = a6;
    return r;
  endfunction

  // Reference: header, payload bytes, XOR of the payload bytes, digit byte
  function automatic frame_t model(input logic [15:0] w0, w1, input bit seen, input logic [3:0] d);
    logic [7:0] pay [4];
    logic [7:0] cs;
    pay[0] = w0[15:8]; pay[1] = w0[7:0]; pay[2] = w1[15:8]; pay[3] = w1[7:0];
    cs = 8'h00;
    foreach (pay[k]) cs = cs ^ pay[k];
    return mk(8'hA5, pay[0], pay[1], pay[2], pay[3], cs, {seen, 3'b000, d});
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rnd0) b0.byte_o_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_w0(input logic [15:0] w);
    pd0 = w; push0 = 1'b1; step(); push0 = 1'b0;
  endtask

  task automatic push_w1(input logic [15:0] w);
    pd1 = w; push1 = 1'b1; step(); push1 = 1'b0;
  endtask

  task automatic pulse_dig0(input logic [3:0] d);
    b0.digit_i = d; b0.digit_i_valid = 1'b1; step(); b0.digit_i_valid = 1'b0;
  endtask

  task automatic wait_done0(input int target);
    int c;
    c = 0;
    while (done0 < target && c < 500) begin step(); c++; end
    chk("frame_done_timeout0", int'(done0 >= target), 1);
  endtask

  task automatic cmp_frame0(input string nm, input int gb, input frame_t e);
    chk({nm, "_len"}, got0.size() - gb, 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_b%0d", nm, i), (gb + i < got0.size()) ? int'(got0[gb + i]) : -1, int'(e[i]));
  endtask

  task automatic run_frame0(input string nm, input logic [15:0] w0, w1, input frame_t e);
    int gb, db, rb;
    gb = got0.size(); db = done0; rb = rd0;
    push_w0(w0); push_w0(w1);
    wait_done0(db + 1);
    rnd0 = 1'b0; b0.byte_o_ready = 1'b1;
    step(); step();
    cmp_frame0(nm, gb, e);
    chk({nm, "_rd_pulses"}, rd0 - rb, 2);
    chk({nm, "_done_pulses"}, done0 - db, 1);
  endtask

  vec_t        tbl [8];
  bit          m_seen;
  logic [3:0]  m_dig;
  logic [15:0] wa, wb;
  int          gb, db, rb, c;
  logic [7:0]  e1 [10];

  initial begin
    rst = 1'b1;
    b0.byte_o_ready = 1'b1; b0.digit_i = '0; b0.digit_i_valid = 1'b0;
    b1.byte_o_ready = 1'b1; b1.digit_i = '0; b1.digit_i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", b0.byte_o_valid, 0);
    chk("rst_byte", b0.byte_o, 0);
    chk("rst_rd_en", b0.fifo_rd_en, 0);
    chk("rst_done", b0.frame_done, 0);
    rst = 1'b0;
    step();

    tbl[0] = '{16'h0001, 16'h0002, 1'b0, 4'd0, 1'b0, mk(8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03, 8'h00)};
    tbl[1] = '{16'h1234, 16'hABCD, 1'b1, 4'd7, 1'b0, mk(8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h87)};
    tbl[2] = '{16'h1234, 16'hABCD, 1'b1, 4'd7, 1'b1, mk(8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h87)};
    for (int i = 3; i < 8; i++)
      tbl[i] = '{16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 1'b1, '0};
    m_seen = 1'b0; m_dig = '0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].dv) begin m_dig = tbl[i].d; m_seen = 1'b1; end
      if (i >= 3) tbl[i].exp = model(tbl[i].w0, tbl[i].w1, m_seen, m_dig);
      m_seen = 1'b0;
    end

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].dv) pulse_dig0(tbl[i].d);
      rnd0 = tbl[i].rnd;
      if (!tbl[i].rnd) b0.byte_o_ready = 1'b1;
      run_frame0($sformatf("vec%0d", i), tbl[i].w0, tbl[i].w1, tbl[i].exp);
    end

    // Mid-frame empty FIFO: stall in RD without reading
    pulse_dig0(4'd7);
    gb = got0.size(); db = done0; rb = rd0;
    push_w0(16'h1234);
    repeat (20) step();
    chk("stall_bytes", got0.size() - gb, 3);
    chk("stall_rd_pulses", rd0 - rb, 1);
    chk("stall_rd_en", b0.fifo_rd_en, 0);
    push_w0(16'hABCD);
    wait_done0(db + 1);
    step(); step();
    cmp_frame0("stall", gb, mk(8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h87));
    chk("stall_rd_total", rd0 - rb, 2);

    // Digit pulse coincident with the digit-byte handshake
    pulse_dig0(4'd3);
    wa = 16'($urandom); wb = 16'($urandom);
    gb = got0.size(); db = done0;
    push_w0(wa); push_w0(wb);
    c = 0;
    while (got0.size() < gb + 6 && c < 100) begin step(); c++; end
    b0.digit_i = 4'd5; b0.digit_i_valid = 1'b1;
    step();
    b0.digit_i_valid = 1'b0;
    wait_done0(db + 1);
    step(); step();
    cmp_frame0("coll", gb, model(wa, wb, 1'b1, 4'd3));
    wa = 16'($urandom); wb = 16'($urandom);
    run_frame0("coll_next", wa, wb, model(wa, wb, 1'b1, 4'd5));
    wa = 16'($urandom); wb = 16'($urandom);
    run_frame0("coll_clear", wa, wb, model(wa, wb, 1'b0, 4'd5));

    // Asynchronous reset mid-payload, after the 0x12 byte is accepted
    b0.byte_o_ready = 1'b1;
    gb = got0.size();
    push_w0(16'h1234); push_w0(16'hABCD);
    c = 0;
    while (got0.size() < gb + 2 && c < 100) begin step(); c++; end
    b0.byte_o_ready = 1'b0;
    step(); step();
    chk("pre_rst_valid", b0.byte_o_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", b0.byte_o_valid, 0);
    chk("arst_byte", b0.byte_o, 0);
    chk("arst_rd_en", b0.fifo_rd_en, 0);
    chk("arst_done", b0.frame_done, 0);
    flush0 = 1'b1;
    step(); step();
    flush0 = 1'b0;
    rst = 1'b0;
    b0.byte_o_ready = 1'b1;
    step();
    chk("post_rst_idle_valid", b0.byte_o_valid, 0);
    run_frame0("post_rst", 16'hABCD, 16'h1234, mk(8'hA5, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h40, 8'h00));

    // Back-to-back single-word frames
    e1 = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hA5, 8'h0F, 8'h0F, 8'h00, 8'h00};
    gb = got1.size(); db = done1; rb = rd1;
    push_w1(16'h00FF); push_w1(16'h0F0F);
    c = 0;
    while (done1 < db + 2 && c < 500) begin step(); c++; end
    chk("fw1_timeout", int'(done1 >= db + 2), 1);
    step(); step();
    chk("fw1_len", got1.size() - gb, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("fw1_b%0d", i), (gb + i < got1.size()) ? int'(got1[gb + i]) : -1, int'(e1[i]));
    chk("fw1_done_pulses", done1 - db, 2);
    chk("fw1_rd_pulses", rd1 - rb, 2);

    chk("rd_while_empty0", viol0, 0);
    chk("unstable_byte0", stab0, 0);
    chk("done_without_xfer0", bad0, 0);
    chk("rd_while_empty1", viol1, 0);
    chk("unstable_byte1", stab1, 0);
    chk("done_without_xfer1", bad1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
